// File: rtl/instruction_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_buffer
// Purpose  : Tag-filtered circular FIFO between fetch and decode; drops stale
//            words after a control-flow change and flags overflow.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_i,
   input  logic [2:0]  tag_i,
   input  logic        flush_i,
   input  logic        ready_i,
   output logic        fetch_enable_o,
   output logic        valid_o,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic [2:0]  expected_tag_o,
   output logic [7:0]  drop_count_o,
   output logic        overflow_o
);

   localparam int C_PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int C_CNT_W = (DEPTH > 3) ? 3 : 2;
   localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(DEPTH - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(DEPTH);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEPTH - 1);

   logic [31:0]        r_instr_mem [DEPTH];
   logic [31:0]        r_pc_mem    [DEPTH];
   logic [C_PTR_W-1:0] r_rd_ptr;
   logic [C_PTR_W-1:0] r_wr_ptr;
   logic [C_CNT_W-1:0] r_count;
   logic [2:0]         r_tag;
   logic [7:0]         r_drop;
   logic               r_overflow;

   logic w_match;
   logic w_stale;
   logic w_pop;
   logic w_push;
   logic w_overflow;

   // Flush masks every other action in the cycle it is asserted.
   always_comb begin
      w_match    = valid_i & ~flush_i & (tag_i == r_tag);
      w_stale    = valid_i & ~flush_i & (tag_i != r_tag);
      w_pop      = (r_count != '0) & ready_i & ~flush_i;
      w_push     = w_match & ((r_count < C_CNT_FULL) | w_pop);
      w_overflow = w_match & (r_count == C_CNT_FULL) & ~w_pop;
   end

   always_comb begin
      fetch_enable_o = reset
                     | (r_count < C_CNT_LAST)
                     | ((r_count == C_CNT_LAST) & ~valid_i)
                     | ready_i;
      valid_o        = (r_count != '0);
      instruction_o  = r_instr_mem[r_rd_ptr];
      pc_o           = r_pc_mem[r_rd_ptr];
      expected_tag_o = r_tag;
      drop_count_o   = r_drop;
      overflow_o     = r_overflow;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_tag      <= '0;
         r_drop     <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr_mem[i] <= '0;
            r_pc_mem[i]    <= '0;
         end
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_tag    <= r_tag + 3'd1;
      end else begin
         if (w_push) begin
            r_instr_mem[r_wr_ptr] <= instruction_i;
            r_pc_mem[r_wr_ptr]    <= pc_i;
            r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_stale && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
         if (w_overflow) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_buffer
// Purpose  : Directed vector table plus corner sequences for instruction_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] instruction_i;
   logic [31:0] pc_i;
   logic [2:0]  tag_i;
   logic        flush_i;
   logic        ready_i;
   logic        fetch_enable_o;
   logic        valid_o;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;
   logic [2:0]  expected_tag_o;
   logic [7:0]  drop_count_o;
   logic        overflow_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_buffer #(.DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_i        (valid_i),
      .instruction_i  (instruction_i),
      .pc_i           (pc_i),
      .tag_i          (tag_i),
      .flush_i        (flush_i),
      .ready_i        (ready_i),
      .fetch_enable_o (fetch_enable_o),
      .valid_o        (valid_o),
      .instruction_o  (instruction_o),
      .pc_o           (pc_o),
      .expected_tag_o (expected_tag_o),
      .drop_count_o   (drop_count_o),
      .overflow_o     (overflow_o)
   );

   typedef struct {
      logic        rst, valid, flush, ready;
      logic [2:0]  tag;
      logic [31:0] instr, pc;
      logic        e_valid;
      logic [31:0] e_instr, e_pc;
      logic [2:0]  e_tag;
      logic [7:0]  e_drop;
      logic        e_ovf, e_fen;
      logic        chk_state, chk_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, valid, flush, ready, input logic [2:0] tag,
                      input logic [31:0] instr, pc, input logic e_valid,
                      input logic [31:0] e_instr, e_pc, input logic [2:0] e_tag,
                      input logic [7:0] e_drop, input logic e_ovf, e_fen,
                      input logic chk_state, chk_data);
      vec_t v;
      v.rst = rst; v.valid = valid; v.flush = flush; v.ready = ready; v.tag = tag;
      v.instr = instr; v.pc = pc; v.e_valid = e_valid; v.e_instr = e_instr;
      v.e_pc = e_pc; v.e_tag = e_tag; v.e_drop = e_drop; v.e_ovf = e_ovf;
      v.e_fen = e_fen; v.chk_state = chk_state; v.chk_data = chk_data;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, valid, flush, ready, input logic [2:0] tag,
                        input logic [31:0] instr, pc);
      reset = rst; valid_i = valid; flush_i = flush; ready_i = ready;
      tag_i = tag; instruction_i = instr; pc_i = pc;
      #1;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      //   rst v  f  r  tag  instr         pc      | ev ei            epc     et ed ov fe  cs cd
      add(1, 0, 0, 0, 0, 32'h0,        32'h0,     0, 32'h0,        32'h0,  0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 32'h0,        32'h0,     0, 32'h0,        32'h0,  0, 0, 0, 1, 1, 1);
      add(0, 1, 0, 1, 7, 32'hAAAAAAAA, 32'h100,   0, 32'h0,        32'h0,  0, 0, 0, 1, 1, 0);
      add(0, 1, 0, 1, 0, 32'h11111111, 32'h0,     0, 32'h0,        32'h0,  0, 1, 0, 1, 1, 0);
      add(0, 1, 0, 1, 0, 32'h22222222, 32'h4,     1, 32'h11111111, 32'h0,  0, 1, 0, 1, 1, 1);
      add(0, 0, 0, 1, 0, 32'h0,        32'h0,     1, 32'h22222222, 32'h4,  0, 1, 0, 1, 1, 1);
      add(0, 1, 0, 0, 0, 32'h33333333, 32'h8,     0, 32'h0,        32'h0,  0, 1, 0, 1, 1, 0);
      add(0, 1, 0, 0, 0, 32'h44444444, 32'hC,     1, 32'h33333333, 32'h8,  0, 1, 0, 0, 1, 1);
      add(0, 1, 0, 0, 0, 32'h55555555, 32'h10,    1, 32'h33333333, 32'h8,  0, 1, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 32'h0,        32'h0,     1, 32'h33333333, 32'h8,  0, 1, 1, 0, 1, 1);
      add(0, 1, 0, 1, 0, 32'h66666666, 32'h14,    1, 32'h33333333, 32'h8,  0, 1, 1, 1, 1, 1);
      add(0, 0, 0, 0, 0, 32'h0,        32'h0,     1, 32'h44444444, 32'hC,  0, 1, 1, 0, 1, 1);
      add(0, 1, 1, 1, 0, 32'h77777777, 32'h18,    1, 32'h44444444, 32'hC,  0, 1, 1, 1, 1, 1);
      add(0, 1, 0, 0, 0, 32'h88888888, 32'h1C,    0, 32'h0,        32'h0,  1, 1, 1, 1, 1, 0);
      add(0, 1, 0, 0, 1, 32'h99999999, 32'h20,    0, 32'h0,        32'h0,  1, 2, 1, 1, 1, 0);
      add(0, 1, 0, 0, 1, 32'hABABABAB, 32'h24,    1, 32'h99999999, 32'h20, 1, 2, 1, 0, 1, 1);
      add(1, 1, 1, 1, 1, 32'hCDCDCDCD, 32'h28,    1, 32'h99999999, 32'h20, 1, 2, 1, 1, 1, 1);
      add(0, 0, 0, 0, 0, 32'h0,        32'h0,     0, 32'h0,        32'h0,  0, 0, 0, 1, 1, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].flush, vecs[i].ready,
               vecs[i].tag, vecs[i].instr, vecs[i].pc);
         if (vecs[i].chk_state) begin
            check($sformatf("v%0d valid", i), 32'(valid_o), 32'(vecs[i].e_valid));
            check($sformatf("v%0d tag", i), 32'(expected_tag_o), 32'(vecs[i].e_tag));
            check($sformatf("v%0d drop", i), 32'(drop_count_o), 32'(vecs[i].e_drop));
            check($sformatf("v%0d overflow", i), 32'(overflow_o), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d fetch_en", i), 32'(fetch_enable_o), 32'(vecs[i].e_fen));
         end
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d instr", i), instruction_o, vecs[i].e_instr);
            check($sformatf("v%0d pc", i), pc_o, vecs[i].e_pc);
         end
         step();
      end

      // Full buffer with simultaneous pop and push: no overflow, order preserved.
      drive(0, 1, 0, 0, 0, 32'hA1, 32'h40);
      step();
      drive(0, 1, 0, 0, 0, 32'hA2, 32'h44);
      check("seqA fetch_en one-left", 32'(fetch_enable_o), 32'd0);
      step();
      drive(0, 1, 0, 1, 0, 32'hA3, 32'h48);
      check("seqA full head", pc_o, 32'h40);
      check("seqA full fetch_en", 32'(fetch_enable_o), 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("seqA overflow", 32'(overflow_o), 32'd0);
      check("seqA head2", pc_o, 32'h44);
      check("seqA still full fetch_en", 32'(fetch_enable_o), 32'd0);
      drive(0, 0, 0, 1, 0, 32'h0, 32'h0);
      step();
      drive(0, 0, 0, 1, 0, 32'h0, 32'h0);
      check("seqA head3 pc", pc_o, 32'h48);
      check("seqA head3 instr", instruction_o, 32'hA3);
      check("seqA head3 valid", 32'(valid_o), 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("seqA drained", 32'(valid_o), 32'd0);

      // Eight flushes with stale fetch words: tag wraps, no drops counted.
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 1, 0, 3'(i + 5), 32'hF0, 32'hF0);
         check($sformatf("seqB tag %0d", i), 32'(expected_tag_o), 32'(i));
         step();
      end
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("seqB tag wrapped", 32'(expected_tag_o), 32'd0);
      check("seqB drop unchanged", 32'(drop_count_o), 32'd0);

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) begin
         drive(0, 1, 0, 1, 3'd3, 32'hBAD, 32'h0);
         if (i == 254) check("seqC drop 254", 32'(drop_count_o), 32'd254);
         if (i == 255) check("seqC drop 255", 32'(drop_count_o), 32'd255);
         step();
      end
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("seqC drop saturated", 32'(drop_count_o), 32'd255);
      check("seqC nothing pushed", 32'(valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
